hpm_counter_bank: RTL and testbench
===================================

HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 The block SHALL take parameter NumCounters, default 6, giving the number of programmable counters (1..29), mapped to mhpmcounter3 onward.
REQ-002 The block SHALL take parameter NumEvents, default 32, giving the width of the event bus (2..32).
REQ-003 The block SHALL take parameter Xlen, default 64, giving the CSR data width (32 or 64); counters are always 64 bits.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; clk_i and rst_ni are named as elsewhere in the core.
REQ-005 Ports (name, direction, width, meaning):
- clk_i, input, 1, clock.
- rst_ni, input, 1, asynchronous active-low reset.
- debug_mode_i, input, 1, core in debug mode.
- addr_i, input, 12, CSR address.
- we_i, input, 1, CSR write strobe.
- data_i, input, Xlen, CSR write data.
- data_o, output, Xlen, CSR read data (combinational).
- access_err_o, output, 1, illegal access to this block (combinational).
- events_i, input, NumEvents, one-cycle event pulses (bit 0 unused).
- ovf_irq_o, output, 1, registered counter-overflow interrupt.

Function
REQ-006 Per counter k, the block SHALL hold: a 64-bit count, a 5-bit event select, an OF (overflow) sticky bit, an inhibit bit.
REQ-007 Address map SHALL be:
- counter k at 0xB03+k;
- high half at 0xB83+k;
- event select at 0x323+k, with the select in bits[4:0] and OF in bit Xlen-1;
- inhibit mask at 0x320, with counter k at bit k+3 and all other bits reading 0.
REQ-008 Counter k SHALL increment by 1 in a cycle only when all of these hold:
- debug_mode_i=0;
- its inhibit bit is 0;
- its select is nonzero and less than NumEvents;
- events_i[select]=1.
REQ-009 A select of 0, or a select ≥ NumEvents, SHALL never count; the stored value is still read back as written.
REQ-010 Increment from 64'hFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 and set OF of that counter in the same cycle.
REQ-011 ovf_irq_o SHALL be a flop equal to the OR of all OF bits, asserting the cycle after OF sets.
REQ-012 OF SHALL clear only by a CSR write of 0 to bit Xlen-1 of that event register; a write of 1 sets it.
REQ-013 A CSR write SHALL update only the addressed register; no other counter is disturbed or cleared.
REQ-014 When a write and an increment target the same counter in the same cycle, the write SHALL win, with no increment and no OF set.
REQ-015 Xlen=32:
- a counter write replaces bits[31:0];
- a high-half write replaces bits[63:32];
- reads return the corresponding half.
REQ-016 Xlen=64:
- counter access is the full 64 bits;
- a high-half address is illegal.
REQ-017 access_err_o SHALL assert for any of:
- an illegal high-half access;
- an address of a counter index ≥ NumCounters within the 29-counter window;
- a write to any unmapped address.
When access_err_o asserts, data_o SHALL be 0 and no state SHALL change.
REQ-018 Reads of unmapped addresses without we_i SHALL return 0 with access_err_o=0.
REQ-019 Counting SHALL continue during a read; data_o SHALL reflect the registered value, i.e. the pre-increment value of that cycle.

Reset
REQ-020 While rst_ni=0 the block SHALL asynchronously clear all counts, selects, OF bits and inhibit bits, and drive ovf_irq_o=0.
REQ-021 data_o and access_err_o SHALL follow REQ-017/018 from reset state.
REQ-022 Reset asserted mid-count SHALL take effect immediately, and counting SHALL resume from 0 on the first clock edge after rst_ni rises.

Verification
REQ-023 Select counter 0 to event 3 (write 0x323=3), pulse events_i[3] for 10 cycles -> read 0xB03 returns 10; counter 1 (select 0) returns 0.
REQ-024 Write 0xB04=64'hFFFF_FFFF_FFFF_FFFE, select 0x324=1, hold events_i[1] for 2 cycles -> count 0, OF=1 in 0x324 bit Xlen-1, ovf_irq_o=1 one cycle after the wrap; write 0x324=1 -> ovf_irq_o falls the next cycle.
REQ-025 Counter 2 counting every cycle, with writes to 0x320=bit5 or debug_mode_i=1 for 4 cycles -> the count is frozen for those 4 cycles, with no loss or gain.
REQ-026 Write 0xB03=100 in the same cycle as its event pulse -> read returns 100; counters 1..5 are unchanged.
REQ-027 Xlen=32: write 0xB83=1 and 0xB03=5 -> 64-bit value 0x1_0000_0005. Xlen=64: access to 0xB83 -> access_err_o=1, data_o=0. NumCounters=6: write 0xB0A -> access_err_o=1.
REQ-028 Assert rst_ni low mid-count with OF set -> all reads return 0, ovf_irq_o=0 immediately.

Source files
------------

// File: rtl/hpm_counter_bank.sv
// Bank of programmable 64-bit hardware performance counters with CSR access.
// Counters sit in the mhpmcounter3.. window, with matching event-select slots and a shared inhibit mask.
module hpm_counter_bank #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned NumEvents   = 32,
  parameter int unsigned Xlen        = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 debug_mode_i,
  input  logic [11:0]          addr_i,
  input  logic                 we_i,
  input  logic [Xlen-1:0]      data_i,
  output logic [Xlen-1:0]      data_o,
  output logic                 access_err_o,
  input  logic [NumEvents-1:0] events_i,
  output logic                 ovf_irq_o
);

  localparam logic [6:0]  CntWin  = 7'h58;  // 0xB00..0xB1F
  localparam logic [6:0]  HiWin   = 7'h5C;  // 0xB80..0xB9F
  localparam logic [6:0]  EvtWin  = 7'h19;  // 0x320..0x33F
  localparam logic [11:0] InhAddr = 12'h320;
  localparam bit          Rv64    = (Xlen == 64);

  logic [63:0]            cnt_q [NumCounters];
  logic [63:0]            cnt_d [NumCounters];
  logic [4:0]             sel_q [NumCounters];
  logic [4:0]             sel_d [NumCounters];
  logic [NumCounters-1:0] of_q, of_d, inh_q, inh_d, inc;
  logic                   ovf_irq_q;

  logic [31:0]     ev_ext;
  logic [4:0]      idx;
  logic            in_cnt, in_hi, in_evt, is_inh, win_hit, idx_ok, mapped, wr;
  logic [Xlen-1:0] rdata;

  assign ev_ext  = 32'(events_i);
  assign idx     = addr_i[4:0] - 5'd3;
  assign in_cnt  = (addr_i[11:5] == CntWin) && (addr_i[4:0] >= 5'd3);
  assign in_hi   = (addr_i[11:5] == HiWin)  && (addr_i[4:0] >= 5'd3);
  assign in_evt  = (addr_i[11:5] == EvtWin) && (addr_i[4:0] >= 5'd3);
  assign is_inh  = (addr_i == InhAddr);
  assign win_hit = in_cnt | in_hi | in_evt;
  assign idx_ok  = 32'(idx) < NumCounters;

  // High-half slots only exist when the CSR width cannot carry all 64 bits.
  assign mapped       = is_inh | (win_hit & idx_ok & ~(in_hi & Rv64));
  assign access_err_o = (win_hit & ~idx_ok) | (in_hi & Rv64) | (we_i & ~mapped);
  assign wr           = we_i & ~access_err_o;
  assign data_o       = access_err_o ? '0 : rdata;
  assign ovf_irq_o    = ovf_irq_q;

  always_comb begin
    for (int k = 0; k < NumCounters; k++) begin
      inc[k] = !debug_mode_i && !inh_q[k] && (sel_q[k] != 5'd0) &&
               (32'(sel_q[k]) < NumEvents) && ev_ext[sel_q[k]];
    end
  end

  always_comb begin
    rdata = '0;
    inh_d = inh_q;
    of_d  = of_q;
    for (int k = 0; k < NumCounters; k++) begin
      cnt_d[k] = cnt_q[k];
      sel_d[k] = sel_q[k];
      if (inc[k]) begin
        cnt_d[k] = cnt_q[k] + 64'd1;
        if (&cnt_q[k]) of_d[k] = 1'b1;
      end
      if (is_inh) begin
        rdata[k+3] = inh_q[k];
        if (wr) inh_d[k] = data_i[k+3];
      end
      if (idx_ok && (idx == 5'(k))) begin
        // A CSR write to the count overrides that cycle's increment and its overflow.
        if (in_cnt) begin
          rdata = Xlen'(cnt_q[k]);
          if (wr) begin
            cnt_d[k] = Rv64 ? 64'(data_i) : {cnt_q[k][63:32], data_i[31:0]};
            of_d[k]  = of_q[k];
          end
        end
        if (in_hi) begin
          rdata = Xlen'(cnt_q[k][63:32]);
          if (wr) begin
            cnt_d[k] = {data_i[31:0], cnt_q[k][31:0]};
            of_d[k]  = of_q[k];
          end
        end
        if (in_evt) begin
          rdata[4:0]    = sel_q[k];
          rdata[Xlen-1] = of_q[k];
          if (wr) begin
            sel_d[k] = data_i[4:0];
            of_d[k]  = data_i[Xlen-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumCounters; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
      end
      of_q      <= '0;
      inh_q     <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      for (int k = 0; k < NumCounters; k++) begin
        cnt_q[k] <= cnt_d[k];
        sel_q[k] <= sel_d[k];
      end
      of_q      <= of_d;
      inh_q     <= inh_d;
      ovf_irq_q <= |of_q;
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed checks of hpm_counter_bank: a 64-bit CSR instance plus a 32-bit, 8-event instance.
module tb_hpm_counter_bank;

  logic        clk, rst_n, debug;
  logic [11:0] addr;
  logic        we0, we1;
  logic [63:0] data;
  logic [31:0] ev;
  logic [7:0]  ev1;
  logic [63:0] d0;
  logic [31:0] d1;
  logic        e0, e1, irq0, irq1;

  int n_chk = 0;
  int n_err = 0;

  hpm_counter_bank #(.NumCounters(6), .NumEvents(32), .Xlen(64)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug), .addr_i(addr), .we_i(we0),
    .data_i(data), .data_o(d0), .access_err_o(e0), .events_i(ev), .ovf_irq_o(irq0)
  );

  hpm_counter_bank #(.NumCounters(6), .NumEvents(8), .Xlen(32)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(debug), .addr_i(addr), .we_i(we1),
    .data_i(data[31:0]), .data_o(d1), .access_err_o(e1), .events_i(ev1), .ovf_irq_o(irq1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic wr0(input logic [11:0] a, input logic [63:0] d);
    addr = a; data = d; we0 = 1'b1;
    @(negedge clk);
    we0 = 1'b0;
  endtask

  task automatic wr1(input logic [11:0] a, input logic [63:0] d);
    addr = a; data = d; we1 = 1'b1;
    @(negedge clk);
    we1 = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [11:0] a, input logic [63:0] exp);
    addr = a;
    #1;
    check(tag, d0, exp);
  endtask

  task automatic rd1(input string tag, input logic [11:0] a, input logic [63:0] exp);
    addr = a;
    #1;
    check(tag, {32'b0, d1}, exp);
  endtask

  initial begin
    rst_n = 1'b0; debug = 1'b0; addr = 12'h0; we0 = 1'b0; we1 = 1'b0;
    data = '0; ev = '0; ev1 = '0;
    repeat (2) @(negedge clk);
    check("rst_irq", {63'b0, irq0}, 64'd0);
    rd0("rst_cnt0", 12'hB03, 64'd0);
    check("rst_err", {63'b0, e0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Counter 0 on event 3 for ten cycles.
    wr0(12'h323, 64'd3);
    ev = 32'h8;
    repeat (10) @(negedge clk);
    ev = '0;
    rd0("cnt0_ten", 12'hB03, 64'd10);
    rd0("cnt1_sel0", 12'hB04, 64'd0);
    rd0("sel0_rb", 12'h323, 64'd3);

    // Wrap of counter 1 and overflow interrupt.
    wr0(12'hB04, 64'hFFFF_FFFF_FFFF_FFFE);
    wr0(12'h324, 64'd1);
    ev = 32'h2;
    repeat (2) @(negedge clk);
    ev = '0;
    rd0("wrap_cnt", 12'hB04, 64'd0);
    rd0("wrap_of", 12'h324, 64'h8000_0000_0000_0001);
    check("irq_not_yet", {63'b0, irq0}, 64'd0);
    @(negedge clk);
    check("irq_set", {63'b0, irq0}, 64'd1);
    wr0(12'h324, 64'd1);
    check("irq_lag", {63'b0, irq0}, 64'd1);
    @(negedge clk);
    check("irq_clr", {63'b0, irq0}, 64'd0);

    // Counter 2 on event 4, frozen by inhibit and then by debug mode.
    wr0(12'h325, 64'd4);
    ev = 32'h10;
    repeat (3) @(negedge clk);
    rd0("c2_run", 12'hB05, 64'd3);
    wr0(12'h320, 64'h20);
    rd0("c2_inh_edge", 12'hB05, 64'd4);
    rd0("inh_rb", 12'h320, 64'h20);
    repeat (4) @(negedge clk);
    rd0("c2_inh_frozen", 12'hB05, 64'd4);
    wr0(12'h320, 64'h0);
    rd0("c2_uninh", 12'hB05, 64'd4);
    @(negedge clk);
    rd0("c2_resume", 12'hB05, 64'd5);
    debug = 1'b1;
    repeat (4) @(negedge clk);
    rd0("c2_dbg_frozen", 12'hB05, 64'd5);
    debug = 1'b0;
    @(negedge clk);
    rd0("c2_dbg_resume", 12'hB05, 64'd6);
    ev = '0;

    // Write collides with an increment on counter 0.
    ev = 32'h8;
    wr0(12'hB03, 64'd100);
    ev = '0;
    rd0("coll_cnt0", 12'hB03, 64'd100);
    rd0("coll_of0", 12'h323, 64'd3);
    rd0("coll_cnt1", 12'hB04, 64'd0);
    rd0("coll_cnt2", 12'hB05, 64'd6);
    rd0("coll_cnt3", 12'hB06, 64'd0);
    rd0("coll_cnt5", 12'hB08, 64'd0);

    // All events high: select 0 must not count.
    ev = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    ev = '0;
    rd0("all_c0", 12'hB03, 64'd102);
    rd0("all_c1", 12'hB04, 64'd2);
    rd0("all_c2", 12'hB05, 64'd8);
    rd0("all_c3_sel0", 12'hB06, 64'd0);

    // Access errors and unmapped addresses.
    rd0("hi_rd_data", 12'hB83, 64'd0);
    check("hi_rd_err", {63'b0, e0}, 64'd1);
    rd0("unmap_rd", 12'h321, 64'd0);
    check("unmap_rd_err", {63'b0, e0}, 64'd0);
    addr = 12'h321; data = 64'h55; we0 = 1'b1;
    #1;
    check("unmap_wr_err", {63'b0, e0}, 64'd1);
    we0 = 1'b0;
    addr = 12'hB0A; data = 64'h55; we0 = 1'b1;
    #1;
    check("idx_wr_err", {63'b0, e0}, 64'd1);
    check("idx_wr_data", d0, 64'd0);
    we0 = 1'b0;
    addr = 12'hB09;
    #1;
    check("idx6_rd_err", {63'b0, e0}, 64'd1);
    addr = 12'hB08;
    #1;
    check("idx5_rd_err", {63'b0, e0}, 64'd0);
    @(negedge clk);
    wr0(12'hB83, 64'hDEAD);
    rd0("err_wr_nochg", 12'hB03, 64'd102);
    wr0(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
    rd0("inh_mask_rb", 12'h320, 64'h1F8);
    wr0(12'h320, 64'h0);

    // 32-bit instance: split halves and out-of-range select.
    wr1(12'hB83, 64'd1);
    wr1(12'hB03, 64'd5);
    rd1("x32_lo", 12'hB03, 64'd5);
    rd1("x32_hi", 12'hB83, 64'd1);
    check("x32_hi_err", {63'b0, e1}, 64'd0);
    wr1(12'h324, 64'd9);
    wr1(12'h325, 64'd7);
    ev1 = 8'hFF;
    repeat (3) @(negedge clk);
    ev1 = '0;
    rd1("x32_sel_big", 12'hB04, 64'd0);
    rd1("x32_sel_rb", 12'h324, 64'd9);
    rd1("x32_sel7", 12'hB05, 64'd3);
    rd1("x32_c0_keep", 12'hB03, 64'd5);

    // Reset mid-count with an overflow pending.
    wr0(12'hB04, 64'hFFFF_FFFF_FFFF_FFFF);
    ev = 32'h2;
    @(negedge clk);
    ev = '0;
    rd0("pre_rst_of", 12'h324, 64'h8000_0000_0000_0001);
    @(negedge clk);
    check("pre_rst_irq", {63'b0, irq0}, 64'd1);
    ev = 32'h10;
    #10;
    rst_n = 1'b0;
    #1;
    check("rst_irq_now", {63'b0, irq0}, 64'd0);
    rd0("rst_c2", 12'hB05, 64'd0);
    rd0("rst_c0", 12'hB03, 64'd0);
    rd0("rst_of1", 12'h324, 64'd0);
    rd1("rst_x32", 12'hB03, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd0("post_rst_idle", 12'hB05, 64'd0);
    wr0(12'h325, 64'd4);
    @(negedge clk);
    rd0("post_rst_count", 12'hB05, 64'd1);
    ev = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
